// File: rtl/dff_pipe.sv
// Parametrised WIDTH x DEPTH register pipeline with per-stage valid, clock enable,
// synchronous flush, a selectable tap and a registered occupancy count.
module dff_pipe #(
    parameter int                WIDTH   = 8,
    parameter int                DEPTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0,
    localparam int               TW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int               CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    input  logic [TW-1:0]    tap_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_vld,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_vld,
    output logic [CW-1:0]    occ,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [CW-1:0]    occ_q;
    logic [CW-1:0]    occ_d;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no branch can infer a latch.
        data_d = data_q;
        vld_d  = vld_q;
        occ_d  = occ_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = RST_VAL;
            end
            vld_d = '0;
            occ_d = '0;
        end else if (ce) begin
            data_d[0] = d;
            vld_d[0]  = d_vld;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
            // Incremental count: one word may enter and one may leave per shift.
            occ_d = occ_q + CW'(d_vld) - CW'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: data stages are reset as well because RST_VAL is visible on q and tap_q.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RST_VAL;
            end
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
            data_q <= data_d;
            vld_q  <= vld_d;
            occ_q  <= occ_d;
        end
    end

    always_comb begin
        tap_q   = RST_VAL;
        tap_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TW'(i)) begin
                tap_q   = data_q[i];
                tap_vld = vld_q[i];
            end
        end
    end

    assign q     = data_q[DEPTH-1];
    assign q_vld = vld_q[DEPTH-1];
    assign occ   = occ_q;
    assign full  = (occ_q == CW'(DEPTH));
    assign empty = (occ_q == '0);

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: vector table for latency, hand sequences for
// stall/flush/tap/reset, and a queue scoreboard for every valid word leaving q.
module tb_dff_pipe;

    localparam logic [7:0] RV  = 8'hC3;
    localparam logic [7:0] RV3 = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_n, ce, clr, d_vld;
    logic [7:0] d;
    logic [1:0] tap_sel;
    logic [7:0] q, tap_q;
    logic       q_vld, tap_vld, full, empty;
    logic [2:0] occ;

    logic [1:0] tap_sel3;
    logic [7:0] q3, tap_q3;
    logic       q_vld3, tap_vld3, full3, empty3;
    logic [1:0] occ3;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb [$];

    typedef struct {
        logic       ce;
        logic       clr;
        logic       dv;
        logic [7:0] d;
        logic [7:0] exp_q;
        logic       exp_vld;
        logic [2:0] exp_occ;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] exp_q;
    } tap_vec_t;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(RV)) u_dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .d(d), .d_vld(d_vld),
        .tap_sel(tap_sel), .q(q), .q_vld(q_vld), .tap_q(tap_q), .tap_vld(tap_vld),
        .occ(occ), .full(full), .empty(empty)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(RV3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .d(d), .d_vld(d_vld),
        .tap_sel(tap_sel3), .q(q3), .q_vld(q_vld3), .tap_q(tap_q3), .tap_vld(tap_vld3),
        .occ(occ3), .full(full3), .empty(empty3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one clock edge; the scoreboard follows every valid word to q.
    task automatic cycle(input logic c, input logic cl, input logic [7:0] dd, input logic dv);
        logic rst_at_edge;
        logic [7:0] exp_word;
        ce = c; clr = cl; d = dd; d_vld = dv;
        @(posedge clk);
        rst_at_edge = rst_n;
        #1;
        if (!rst_at_edge || cl) begin
            sb.delete();
        end else if (c) begin
            if (dv) sb.push_back(dd);
            if (q_vld) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got q=%0h with no word expected", q);
                end else begin
                    exp_word = sb.pop_front();
                    check("sb_q", 32'(q), 32'(exp_word));
                end
            end
        end
        check("occ_vs_inflight", 32'(occ), 32'(sb.size()) + 32'(q_vld));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_q"}, 32'(q), 32'(RV));
        check({tag, "_q_vld"}, 32'(q_vld), 32'd0);
        check({tag, "_occ"}, 32'(occ), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
    endtask

    initial begin
        vec_t     lat_tbl [7];
        tap_vec_t tap_tbl [4];

        lat_tbl[0] = '{1'b1, 1'b0, 1'b1, 8'h11, RV,    1'b0, 3'd1};
        lat_tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h22, RV,    1'b0, 3'd2};
        lat_tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h33, RV,    1'b0, 3'd3};
        lat_tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h11, 1'b1, 3'd3};
        lat_tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h22, 1'b1, 3'd2};
        lat_tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h33, 1'b1, 3'd1};
        lat_tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0};

        tap_tbl[0] = '{2'd0, 8'hA3};
        tap_tbl[1] = '{2'd1, 8'hA2};
        tap_tbl[2] = '{2'd2, 8'hA1};
        tap_tbl[3] = '{2'd3, 8'hA0};

        rst_n = 1'b0; ce = 1'b1; clr = 1'b0; d = 8'($urandom); d_vld = 1'b1;
        tap_sel = 2'd3; tap_sel3 = 2'd3;

        // Reset with random data and ce active.
        cycle(1'b1, 1'b0, 8'($urandom), 1'b1);
        cycle(1'b1, 1'b0, 8'($urandom), 1'b1);
        check_idle("reset");
        check("reset_tap_vld", 32'(tap_vld), 32'd0);
        check("reset_tap_q", 32'(tap_q), 32'(RV));
        rst_n = 1'b1;

        // Latency table.
        for (int i = 0; i < 7; i++) begin
            cycle(lat_tbl[i].ce, lat_tbl[i].clr, lat_tbl[i].d, lat_tbl[i].dv);
            check($sformatf("lat%0d_q", i), 32'(q), 32'(lat_tbl[i].exp_q));
            check($sformatf("lat%0d_q_vld", i), 32'(q_vld), 32'(lat_tbl[i].exp_vld));
            check($sformatf("lat%0d_occ", i), 32'(occ), 32'(lat_tbl[i].exp_occ));
            check($sformatf("lat%0d_empty", i), 32'(empty), 32'(lat_tbl[i].exp_occ == 3'd0));
        end

        // Stall: fill four words, hold five cycles with noisy inputs, then drain.
        tap_sel = 2'd0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h41 + 8'(i), 1'b1);
        check("stall_fill_full", 32'(full), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, 8'($urandom), k[0]);
            check("stall_q", 32'(q), 32'h41);
            check("stall_q_vld", 32'(q_vld), 32'd1);
            check("stall_occ", 32'(occ), 32'd4);
            check("stall_full", 32'(full), 32'd1);
            check("stall_tap0", 32'(tap_q), 32'h44);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_q_vld", 32'(q_vld), 32'd0);

        // Flush mid-flight, together with ce and a valid input.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h51 + 8'(i), 1'b1);
        check("flush_pre_occ", 32'(occ), 32'd3);
        cycle(1'b1, 1'b1, 8'h99, 1'b1);
        check_idle("flush");
        check("flush_tap0", 32'(tap_q), 32'(RV));
        cycle(1'b1, 1'b0, 8'h77, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b0);
            check("flush_refill_early", 32'(q_vld), 32'd0);
        end
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check("flush_refill_q", 32'(q), 32'h77);
        check("flush_refill_q_vld", 32'(q_vld), 32'd1);

        // Tap sweep on a held pipe; the DEPTH=3 copy sees an out-of-range tap.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b1);
        ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tap_sel = tap_tbl[i].sel;
            #1;
            check($sformatf("tap%0d_q", i), 32'(tap_q), 32'(tap_tbl[i].exp_q));
            check($sformatf("tap%0d_vld", i), 32'(tap_vld), 32'd1);
        end
        check("d3_tap_oor_q", 32'(tap_q3), 32'(RV3));
        check("d3_tap_oor_vld", 32'(tap_vld3), 32'd0);
        check("d3_q", 32'(q3), 32'hA1);
        check("d3_full", 32'(full3), 32'd1);

        // Steady state from empty: occ saturates and stays full.
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b0, 8'h60 + 8'(k), 1'b1);
            check("steady_occ", 32'(occ), (k < 3) ? 32'(k + 1) : 32'd4);
            check("steady_full", 32'(full), (k >= 3) ? 32'd1 : 32'd0);
        end

        // Reset pulse mid-operation, then refill; a glitch between edges is ignored.
        rst_n = 1'b0;
        cycle(1'b1, 1'b0, 8'hEE, 1'b1);
        check_idle("midrst");
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 8'h70, 1'b1);
        check("refill_occ", 32'(occ), 32'd1);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        cycle(1'b1, 1'b0, 8'h71, 1'b1);
        check("glitch_occ", 32'(occ), 32'd2);
        tap_sel = 2'd1;
        #1;
        check("glitch_tap1", 32'(tap_q), 32'h70);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check("final_empty", 32'(empty), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
